// File: rtl/aes_vector_driver.sv
// Vector RAM plus sequencer that drives AES_top one vector at a time and scores its results.
// Optional build macro AES_DRV_CAPTURE_EN adds fail_data_out (output of first mismatching vector).
module aes_vector_driver #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 64,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic          AES_clk,
   input  logic          AES_rst_n,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [AW-1:0] cfg_addr,
   input  logic [127:0]  cfg_wdata,
   input  logic [AW:0]   cfg_num,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   pass_cnt,
   output logic [AW:0]   fail_cnt,
   output logic          timeout_flag,
   output logic [AW-1:0] first_fail_idx,
`ifdef AES_DRV_CAPTURE_EN
   output logic [127:0]  fail_data_out,
`endif
   output logic          AES_en,
   output logic [127:0]  AES_data_in,
   output logic [127:0]  AES_key_in,
   input  logic [127:0]  AES_data_out,
   input  logic          AES_data_out_valid
);

   localparam int CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW     = $clog2(CntMax + 1);
   localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);
   localparam logic [AW:0] One    = (AW + 1)'(1);

   typedef enum logic [2:0] {StIdle, StSetup, StRun, StCheck, StGap, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW:0]     run_q, run_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW:0]     pass_q, pass_d;
   logic [AW:0]     fail_q, fail_d;
   logic            tmo_q, tmo_d;
   logic [AW-1:0]   ffi_q, ffi_d;
   logic [127:0]    data_q, data_d;
   logic [127:0]    key_q, key_d;
   logic [127:0]    cap_q, cap_d;
`ifdef AES_DRV_CAPTURE_EN
   logic [127:0]    fdata_q, fdata_d;
`endif

   logic [127:0]    pt_ram  [DEPTH];
   logic [127:0]    key_ram [DEPTH];
   logic [127:0]    exp_ram [DEPTH];

   // Vector RAM is not reset; writes only land while idle.
   always_ff @(posedge AES_clk) begin
      if (cfg_we && state_q == StIdle) begin
         case (cfg_sel)
            2'd0:    pt_ram[cfg_addr]  <= cfg_wdata;
            2'd1:    key_ram[cfg_addr] <= cfg_wdata;
            2'd2:    exp_ram[cfg_addr] <= cfg_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge AES_clk) begin
      if (!AES_rst_n) begin
         state_q <= StIdle;
         run_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         tmo_q   <= 1'b0;
         ffi_q   <= '0;
         data_q  <= '0;
         key_q   <= '0;
         cap_q   <= '0;
`ifdef AES_DRV_CAPTURE_EN
         fdata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         ffi_q   <= ffi_d;
         data_q  <= data_d;
         key_q   <= key_d;
         cap_q   <= cap_d;
`ifdef AES_DRV_CAPTURE_EN
         fdata_q <= fdata_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      ffi_d   = ffi_q;
      data_d  = data_q;
      key_d   = key_q;
      cap_d   = cap_q;
`ifdef AES_DRV_CAPTURE_EN
      fdata_d = fdata_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               run_d  = cfg_num;
               idx_d  = '0;
               cnt_d  = '0;
               pass_d = '0;
               fail_d = '0;
               tmo_d  = 1'b0;
               ffi_d  = '0;
`ifdef AES_DRV_CAPTURE_EN
               fdata_d = '0;
`endif
               // An out-of-range count skips straight to the done pulse.
               if (cfg_num == '0 || cfg_num > DepthW) state_d = StDone;
               else                                   state_d = StSetup;
            end
         end
         StSetup: begin
            data_d  = pt_ram[idx_q];
            key_d   = key_ram[idx_q];
            cnt_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            if (AES_data_out_valid) begin
               cap_d   = AES_data_out;
               state_d = StCheck;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               if (fail_q == '0) ffi_d = idx_q;
               fail_d  = fail_q + One;
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StCheck: begin
            if (cap_q == exp_ram[idx_q]) begin
               pass_d = pass_q + One;
            end else begin
               if (fail_q == '0) begin
                  ffi_d = idx_q;
`ifdef AES_DRV_CAPTURE_EN
                  fdata_d = cap_q;
`endif
               end
               fail_d = fail_q + One;
            end
            cnt_d   = '0;
            state_d = StGap;
         end
         StGap: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               if ({1'b0, idx_q} == run_q - One) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = StSetup;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign busy           = state_q inside {StSetup, StRun, StCheck, StGap};
   assign done           = (state_q == StDone);
   assign AES_en         = (state_q == StRun);
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign timeout_flag   = tmo_q;
   assign first_fail_idx = ffi_q;
   assign AES_data_in    = data_q;
   assign AES_key_in     = key_q;
`ifdef AES_DRV_CAPTURE_EN
   assign fail_data_out  = fdata_q;
`endif

endmodule
